// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI mode-0 responder that stands in for the slide-pot ADC.
// Each 16-bit frame returns the 12-bit conversion value for the channel
// latched by the previous frame. It also latches a new channel from MOSI
// bits [13:11]. All SPI pins are oversampled in the clk domain.
module a2d_spi_resp #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [2:0]  RST_CHNNL   = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic [2:0]  chnnl,
  input  logic [11:0] ch_data,
  output logic        frm_cmplt,
  output logic        frm_err
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Synchronizer chains, edge-detect flops and registered edge strobes.
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   ss_dly_q;
  logic                   sclk_dly_q;
  logic                   mosi_dly_q;
  logic                   ss_fall_q;
  logic                   ss_rise_q;
  logic                   sclk_rise_q;
  logic                   sclk_fall_q;

  // Frame state.
  state_e      state_q;
  logic [15:0] tx_shft_q;
  logic [15:0] rx_shft_q;
  logic [4:0]  bit_cnt_q;
  logic [2:0]  chnnl_q;
  logic        frm_cmplt_q;
  logic        frm_err_q;

  // Next values of the shift datapath after this cycle's SCLK edge.
  logic [15:0] tx_nxt_s;
  logic [15:0] rx_nxt_s;
  logic [4:0]  cnt_nxt_s;

  // Synchronize the pins, delay once more and register the edge strobes.
  // The SS_n chain resets low so that SS_n held low across reset release
  // cannot produce a fall: the block needs SS_n high first, then a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_dly_q    <= 1'b0;
      sclk_dly_q  <= 1'b0;
      mosi_dly_q  <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_dly_q    <= ss_sync_q[SYNC_STAGES-1];
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
      // MOSI is delayed alongside the strobes so it lines up with sclk_rise_q.
      mosi_dly_q  <= mosi_sync_q[SYNC_STAGES-1];
      ss_fall_q   <= ss_dly_q & ~ss_sync_q[SYNC_STAGES-1];
      ss_rise_q   <= ~ss_dly_q & ss_sync_q[SYNC_STAGES-1];
      sclk_rise_q <= ~sclk_dly_q & sclk_sync_q[SYNC_STAGES-1];
      sclk_fall_q <= sclk_dly_q & ~sclk_sync_q[SYNC_STAGES-1];
    end
  end

  // Apply this cycle's SCLK edge to the shifters before any frame-end check.
  // A coincident 16th rise is then counted. A fall before the first rise is
  // ignored.
  always_comb begin
    tx_nxt_s  = tx_shft_q;
    rx_nxt_s  = rx_shft_q;
    cnt_nxt_s = bit_cnt_q;
    if (sclk_rise_q) begin
      rx_nxt_s  = {rx_shft_q[14:0], mosi_dly_q};
      cnt_nxt_s = (bit_cnt_q == 5'd31) ? bit_cnt_q : (bit_cnt_q + 5'd1);
    end else if (sclk_fall_q && (bit_cnt_q != 5'd0)) begin
      tx_nxt_s  = {tx_shft_q[14:0], 1'b0};
    end else begin
      tx_nxt_s  = tx_shft_q;
    end
  end

  // Frame FSM: load on SS_n fall, shift while selected, judge the frame on SS_n rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_shft_q   <= 16'h0000;
      rx_shft_q   <= 16'h0000;
      bit_cnt_q   <= 5'd0;
      chnnl_q     <= RST_CHNNL;
      frm_cmplt_q <= 1'b0;
      frm_err_q   <= 1'b0;
    end else begin
      frm_cmplt_q <= 1'b0;
      frm_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= 5'd0;
          rx_shft_q <= 16'h0000;
          if (ss_fall_q) begin
            // ch_data is sampled here only, once per frame.
            tx_shft_q <= {4'h0, ch_data};
            state_q   <= ST_SHIFT;
          end else begin
            tx_shft_q <= 16'h0000;
          end
        end
        ST_SHIFT: begin
          if (ss_rise_q) begin
            state_q   <= ST_IDLE;
            tx_shft_q <= 16'h0000;
            rx_shft_q <= 16'h0000;
            bit_cnt_q <= 5'd0;
            if (cnt_nxt_s == 5'd16) begin
              chnnl_q     <= rx_nxt_s[13:11];
              frm_cmplt_q <= 1'b1;
            end else begin
              frm_err_q   <= 1'b1;
            end
          end else begin
            tx_shft_q <= tx_nxt_s;
            rx_shft_q <= rx_nxt_s;
            bit_cnt_q <= cnt_nxt_s;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          tx_shft_q <= 16'h0000;
          rx_shft_q <= 16'h0000;
          bit_cnt_q <= 5'd0;
        end
      endcase
    end
  end

  // tx_shft_q is held at zero outside a frame, so MISO comes straight from a flop.
  assign MISO      = tx_shft_q[15];
  assign chnnl     = chnnl_q;
  assign frm_cmplt = frm_cmplt_q;
  assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed self-checking bench for a2d_spi_resp (SCLK = clk/32).
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [2:0]  chnnl;
  logic [11:0] ch_data;
  logic        frm_cmplt;
  logic        frm_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int n_cmplt = 0;
  int n_err   = 0;
  int c0;
  int e0;
  logic [31:0] rd;
  logic [15:0] sh;

  always #10 clk = ~clk;

  a2d_spi_resp #(.SYNC_STAGES(2), .RST_CHNNL(3'b000)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .chnnl(chnnl), .ch_data(ch_data),
    .frm_cmplt(frm_cmplt), .frm_err(frm_err)
  );

  // Count frame-end pulses.
  always @(posedge clk) begin
    if (frm_cmplt) n_cmplt <= n_cmplt + 1;
    if (frm_err)   n_err   <= n_err + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One SPI frame. MISO is sampled just before each rise.
  // chg_tick>0 switches ch_data to chg_val that many clks after SS_n falls.
  // coinc makes the last SCLK rise coincide with SS_n rise.
  task automatic frame(input logic [15:0] w, input int nrise, input logic [11:0] cd,
                       input int chg_tick, input logic [11:0] chg_val, input bit coinc,
                       output logic [31:0] rdo);
    logic [15:0] s;
    rdo = 32'h0;
    s = w;
    ch_data = cd;
    MOSI = s[15];
    SS_n = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      if (t == chg_tick) ch_data = chg_val;
    end
    for (int i = 0; i < nrise; i++) begin
      rdo = {rdo[30:0], MISO};
      SCLK = 1'b1;
      if (coinc && (i == nrise - 1)) begin
        SS_n = 1'b1;
      end else begin
        tick(16);
        SCLK = 1'b0;
        s = {s[14:0], 1'b0};
        MOSI = s[15];
        tick(16);
      end
    end
    SS_n = 1'b1;
    tick(3);
    chk("pulse_early", 32'(frm_cmplt | frm_err), 32'h0);
    tick(1);
    chk("pulse_latency", 32'(frm_cmplt | frm_err), 32'h1);
    SCLK = 1'b0;
    MOSI = 1'b0;
    tick(6);
  endtask

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; ch_data = 12'h000;
    tick(3);
    chk("rst_miso",  32'(MISO), 32'h0);
    chk("rst_chnnl", 32'(chnnl), 32'h0);
    chk("rst_cmplt", 32'(frm_cmplt), 32'h0);
    chk("rst_err",   32'(frm_err), 32'h0);
    rst_n = 1'b1;
    tick(6);

    // Back-to-back frames, ch_data = 0x100 + current channel.
    frame(16'h0800, 16, 12'h100, 0, 12'h000, 1'b0, rd);
    chk("b2b0_word", 32'(rd[15:0]), 32'h0100);
    chk("b2b0_chnnl", 32'(chnnl), 32'h1);
    frame(16'h3800, 16, 12'h101, 0, 12'h000, 1'b0, rd);
    chk("b2b1_word", 32'(rd[15:0]), 32'h0101);
    chk("b2b1_chnnl", 32'(chnnl), 32'h7);
    frame(16'h0000, 16, 12'h107, 0, 12'h000, 1'b0, rd);
    chk("b2b2_word", 32'(rd[15:0]), 32'h0107);
    chk("b2b2_chnnl", 32'(chnnl), 32'h0);
    chk("b2b_cmplt_cnt", 32'(n_cmplt), 32'd3);
    chk("b2b_err_cnt", 32'(n_err), 32'd0);

    // Command then read.
    frame(16'h1800, 16, 12'h000, 0, 12'h000, 1'b0, rd);
    chk("cmd_chnnl", 32'(chnnl), 32'h3);
    chk("cmd_cmplt_cnt", 32'(n_cmplt), 32'd4);
    frame(16'h2800, 16, 12'hA5C, 0, 12'h000, 1'b0, rd);
    chk("read_word", 32'(rd[15:0]), 32'h0A5C);
    chk("read_chnnl", 32'(chnnl), 32'h5);

    // 16th rise coincident with SS_n rise still counts.
    frame(16'h1000, 16, 12'h3C3, 0, 12'h000, 1'b1, rd);
    chk("coinc_word", 32'(rd[15:0]), 32'h03C3);
    chk("coinc_chnnl", 32'(chnnl), 32'h2);
    chk("coinc_cmplt_cnt", 32'(n_cmplt), 32'd6);
    chk("coinc_err_cnt", 32'(n_err), 32'd0);

    // Short frame: 10 rises.
    frame(16'h3800, 10, 12'hABC, 0, 12'h000, 1'b0, rd);
    chk("short_bits", 32'(rd[9:0]), 32'h02A);
    chk("short_chnnl", 32'(chnnl), 32'h2);
    chk("short_err_cnt", 32'(n_err), 32'd1);
    chk("short_cmplt_cnt", 32'(n_cmplt), 32'd6);

    // Long frame: 20 rises, zeros after bit 0.
    frame(16'h3800, 20, 12'hABC, 0, 12'h000, 1'b0, rd);
    chk("long_bits", 32'(rd[19:0]), 32'h0ABC0);
    chk("long_chnnl", 32'(chnnl), 32'h2);
    chk("long_err_cnt", 32'(n_err), 32'd2);
    chk("long_cmplt_cnt", 32'(n_cmplt), 32'd6);

    // ch_data changes 2 clks after the fall is detected (sampled at clk 4).
    frame(16'h3000, 16, 12'h123, 6, 12'hFFF, 1'b0, rd);
    chk("chg_word", 32'(rd[15:0]), 32'h0123);
    chk("chg_chnnl", 32'(chnnl), 32'h6);

    // Reset mid-frame after 7 rises.
    ch_data = 12'hFFF;
    sh = 16'h3800;
    MOSI = sh[15];
    SS_n = 1'b0;
    tick(8);
    for (int i = 0; i < 7; i++) begin
      SCLK = 1'b1;
      tick(16);
      SCLK = 1'b0;
      sh = {sh[14:0], 1'b0};
      MOSI = sh[15];
      tick(16);
    end
    chk("mid_miso_before", 32'(MISO), 32'h1);
    c0 = n_cmplt;
    e0 = n_err;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_miso", 32'(MISO), 32'h0);
    chk("mid_rst_chnnl", 32'(chnnl), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick(10);
    chk("mid_no_cmplt", 32'(n_cmplt - c0), 32'd0);
    chk("mid_no_err", 32'(n_err - e0), 32'd0);
    frame(16'h0800, 16, 12'h055, 0, 12'h000, 1'b0, rd);
    chk("post_rst_word", 32'(rd[15:0]), 32'h0055);
    chk("post_rst_chnnl", 32'(chnnl), 32'h1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
